// File: rtl/alu_instr_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions.
// Drives datapath load strobes, bus select, MD_Read and ALU opcode from state and IR.
module alu_instr_sequencer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic [31:0]      enable,
  output logic [31:0]      bus_select,
  output logic             md_read,
  output logic [3:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;

  logic [31:0] en_c, bs_c;
  logic        mdr_c;
  logic [3:0]  aop_c;

  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic       unused_ir;

  assign ir_op     = ir[31:27];
  assign ir_ra     = ir[26:23];
  assign ir_rb     = ir[22:19];
  assign ir_rc     = ir[18:15];
  assign unused_ir = ^ir[14:0];

  // Opcode to ALU control; zero marks an unsupported opcode.
  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      5'b00011: alu_code = 4'd1;
      5'b00100: alu_code = 4'd2;
      5'b00101: alu_code = 4'd3;
      5'b00110: alu_code = 4'd4;
      default:  alu_code = 4'd0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    en_c      = '0;
    bs_c      = '0;
    mdr_c     = 1'b0;
    aop_c     = 4'd0;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        bs_c[20] = 1'b1;
        en_c[25] = 1'b1;
        en_c[28] = 1'b1;
        en_c[24] = 1'b1;
        state_d  = S_T1;
      end
      S_T1: begin
        bs_c[19] = 1'b1;
        en_c[20] = 1'b1;
        en_c[21] = 1'b1;
        mdr_c    = 1'b1;
        // mem_ready takes priority over the timeout on the limit cycle
        if (mem_ready) begin
          wait_d  = '0;
          state_d = S_T2;
        end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
          wait_d    = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_T2: begin
        bs_c[21] = 1'b1;
        en_c[23] = 1'b1;
        state_d  = S_T3;
      end
      S_T3: begin
        if (alu_code(ir_op) != 4'd0) begin
          bs_c[{1'b0, ir_rb}] = 1'b1;
          en_c[27]            = 1'b1;
          state_d             = S_T4;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_T4: begin
        bs_c[{1'b0, ir_rc}] = 1'b1;
        aop_c               = alu_code(ir_op);
        en_c[24]            = 1'b1;
        state_d             = S_T5;
      end
      S_T5: begin
        bs_c[19]            = 1'b1;
        en_c[{1'b0, ir_ra}] = 1'b1;
        done_d              = 1'b1;
        cnt_d               = cnt_q + 1'b1;
        state_d             = start ? S_T0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Every output is held low while clr is asserted.
  assign enable      = clr ? '0 : en_c;
  assign bus_select  = clr ? '0 : bs_c;
  assign md_read     = ~clr & mdr_c;
  assign alu_op      = clr ? 4'd0 : aop_c;
  assign busy        = ~clr & (state_q != S_IDLE);
  assign done        = ~clr & done_q;
  assign illegal     = ~clr & illegal_q;
  assign mem_timeout = ~clr & timeout_q;
  assign state       = clr ? 4'd0 : state_q;
  assign instr_count = clr ? '0 : cnt_q;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: per-cycle vector table plus
// hand-written memory-wait, timeout and mid-instruction reset sequences.
module tb_alu_instr_sequencer;

  logic        clk = 1'b0;
  logic        clr, start, mem_ready;
  logic [31:0] ir;
  logic [31:0] enable, bus_select;
  logic        md_read, busy, done, illegal, mem_timeout;
  logic [3:0]  alu_op, state;
  logic [15:0] instr_count;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [31:0] IR_AND = 32'h28918000; // R1 = R2 & R3
  localparam logic [31:0] IR_ADD = 32'h18918000; // R1 = R2 + R3
  localparam logic [31:0] IR_OR  = 32'h32090000; // R4 = R1 | R2
  localparam logic [31:0] IR_BAD = 32'hF8000000;

  always #5 clk = ~clk;

  alu_instr_sequencer #(.MEM_WAIT_MAX(15), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .enable(enable), .bus_select(bus_select), .md_read(md_read), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal), .mem_timeout(mem_timeout),
    .state(state), .instr_count(instr_count)
  );

  typedef struct packed {
    logic        clr;
    logic        start;
    logic        mr;
    logic [31:0] ir;
    logic [92:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [92:0] pack_obs(
    input logic [3:0] st, input logic [31:0] en, input logic [31:0] bs,
    input logic mdr, input logic [3:0] aop, input logic bsy, input logic dn,
    input logic ill, input logic tmo, input logic [15:0] cnt);
    return {st, en, bs, mdr, aop, bsy, dn, ill, tmo, cnt};
  endfunction

  task automatic addv(input logic c, input logic s, input logic m, input logic [31:0] i,
                      input logic [3:0] st, input logic [31:0] en, input logic [31:0] bs,
                      input logic mdr, input logic [3:0] aop, input logic bsy,
                      input logic dn, input logic ill, input logic tmo, input logic [15:0] cnt);
    vec_t v;
    v.clr = c; v.start = s; v.mr = m; v.ir = i;
    v.exp = pack_obs(st, en, bs, mdr, aop, bsy, dn, ill, tmo, cnt);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [92:0] obs;
    int t1seen, done_cyc, tmo_seen, guard;
    logic mdr_ok, reg_wr;

    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;

    // reset, then single AND with zero-wait memory
    addv(1,0,0,0,      4'd0, 32'h0,        32'h0,        0,4'd0,0,0,0,0,16'd0);
    addv(1,0,0,0,      4'd0, 32'h0,        32'h0,        0,4'd0,0,0,0,0,16'd0);
    addv(0,1,0,0,      4'd0, 32'h0,        32'h0,        0,4'd0,0,0,0,0,16'd0);
    addv(0,0,0,0,      4'd1, 32'h13000000, 32'h00100000, 0,4'd0,1,0,0,0,16'd0);
    addv(0,0,1,0,      4'd2, 32'h00300000, 32'h00080000, 1,4'd0,1,0,0,0,16'd0);
    addv(0,0,0,IR_AND, 4'd3, 32'h00800000, 32'h00200000, 0,4'd0,1,0,0,0,16'd0);
    addv(0,0,0,IR_AND, 4'd4, 32'h08000000, 32'h00000004, 0,4'd0,1,0,0,0,16'd0);
    addv(0,0,0,IR_AND, 4'd5, 32'h01000000, 32'h00000008, 0,4'd3,1,0,0,0,16'd0);
    addv(0,0,0,IR_AND, 4'd6, 32'h00000002, 32'h00080000, 0,4'd0,1,0,0,0,16'd0);
    addv(0,0,0,IR_AND, 4'd0, 32'h0,        32'h0,        0,4'd0,0,1,0,0,16'd1);
    // illegal opcode: no Yin/Zin, back to IDLE, count unchanged
    addv(0,1,0,IR_AND, 4'd0, 32'h0,        32'h0,        0,4'd0,0,0,0,0,16'd1);
    addv(0,0,0,IR_AND, 4'd1, 32'h13000000, 32'h00100000, 0,4'd0,1,0,0,0,16'd1);
    addv(0,0,1,IR_AND, 4'd2, 32'h00300000, 32'h00080000, 1,4'd0,1,0,0,0,16'd1);
    addv(0,0,0,IR_BAD, 4'd3, 32'h00800000, 32'h00200000, 0,4'd0,1,0,0,0,16'd1);
    addv(0,0,0,IR_BAD, 4'd4, 32'h0,        32'h0,        0,4'd0,1,0,0,0,16'd1);
    addv(0,0,0,IR_BAD, 4'd0, 32'h0,        32'h0,        0,4'd0,0,0,1,0,16'd1);
    // back-to-back ADD then OR with start held
    addv(0,1,0,IR_BAD, 4'd0, 32'h0,        32'h0,        0,4'd0,0,0,0,0,16'd1);
    addv(0,1,0,IR_BAD, 4'd1, 32'h13000000, 32'h00100000, 0,4'd0,1,0,0,0,16'd1);
    addv(0,1,1,IR_BAD, 4'd2, 32'h00300000, 32'h00080000, 1,4'd0,1,0,0,0,16'd1);
    addv(0,1,0,IR_ADD, 4'd3, 32'h00800000, 32'h00200000, 0,4'd0,1,0,0,0,16'd1);
    addv(0,1,0,IR_ADD, 4'd4, 32'h08000000, 32'h00000004, 0,4'd0,1,0,0,0,16'd1);
    addv(0,1,0,IR_ADD, 4'd5, 32'h01000000, 32'h00000008, 0,4'd1,1,0,0,0,16'd1);
    addv(0,1,0,IR_ADD, 4'd6, 32'h00000002, 32'h00080000, 0,4'd0,1,0,0,0,16'd1);
    addv(0,1,0,IR_ADD, 4'd1, 32'h13000000, 32'h00100000, 0,4'd0,1,1,0,0,16'd2);
    addv(0,1,1,IR_ADD, 4'd2, 32'h00300000, 32'h00080000, 1,4'd0,1,0,0,0,16'd2);
    addv(0,1,0,IR_OR,  4'd3, 32'h00800000, 32'h00200000, 0,4'd0,1,0,0,0,16'd2);
    addv(0,1,0,IR_OR,  4'd4, 32'h08000000, 32'h00000002, 0,4'd0,1,0,0,0,16'd2);
    addv(0,1,0,IR_OR,  4'd5, 32'h01000000, 32'h00000004, 0,4'd4,1,0,0,0,16'd2);
    addv(0,0,0,IR_OR,  4'd6, 32'h00000010, 32'h00080000, 0,4'd0,1,0,0,0,16'd2);
    addv(0,0,0,IR_OR,  4'd0, 32'h0,        32'h0,        0,4'd0,0,1,0,0,16'd3);

    tick();
    foreach (vecs[i]) begin
      clr = vecs[i].clr; start = vecs[i].start; mem_ready = vecs[i].mr; ir = vecs[i].ir;
      @(negedge clk);
      obs = pack_obs(state, enable, bus_select, md_read, alu_op, busy, done,
                     illegal, mem_timeout, instr_count);
      chk($sformatf("vec[%0d]", i), 128'(obs), 128'(vecs[i].exp));
      tick();
    end
    start = 1'b0; mem_ready = 1'b0;

    // memory wait: ready on the 4th T1 cycle
    ir = IR_AND; t1seen = 0; done_cyc = -1; mdr_ok = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      start = (cyc == 0);
      if (state == 4'd2) begin
        t1seen++;
        if (!md_read) mdr_ok = 1'b0;
      end
      mem_ready = (state == 4'd2) && (t1seen == 4);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    mem_ready = 1'b0; start = 1'b0;
    chk("wait_t1_cycles", 128'(t1seen), 128'(4));
    chk("wait_md_read", 128'(mdr_ok), 128'(1));
    chk("wait_done_cycle", 128'(done_cyc), 128'(10));
    chk("wait_count", 128'(instr_count), 128'(4));

    // timeout: mem_ready never arrives
    tick();
    t1seen = 0; tmo_seen = 0; reg_wr = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      start = (cyc == 0);
      if (state == 4'd2) t1seen++;
      if (enable[15:0] != 16'h0) reg_wr = 1'b1;
      if (mem_timeout) begin
        tmo_seen = 1;
        chk("tmo_state", 128'(state), 128'(0));
        break;
      end
      tick();
    end
    start = 1'b0;
    chk("tmo_pulse_seen", 128'(tmo_seen), 128'(1));
    chk("tmo_t1_cycles", 128'(t1seen), 128'(15));
    chk("tmo_no_reg_write", 128'(reg_wr), 128'(0));
    chk("tmo_count", 128'(instr_count), 128'(4));
    tick();
    chk("tmo_pulse_one_cycle", 128'(mem_timeout), 128'(0));

    // reset held 2 cycles mid-T4
    ir = IR_AND; mem_ready = 1'b1; start = 1'b1;
    guard = 0;
    while (state != 4'd5 && guard < 20) begin
      tick();
      start = 1'b0;
      guard++;
    end
    chk("rst_reached_t4", 128'(state), 128'(5));
    clr = 1'b1; start = 1'b0;
    #1;
    chk("rst_outputs_forced", 128'({state, enable, bus_select, md_read, alu_op, busy}),
        128'(0));
    tick();
    tick();
    clr = 1'b0;
    #1;
    chk("rst_after", 128'({state, enable, bus_select, md_read, done, instr_count}), 128'(0));
    tick();
    chk("rst_no_done", 128'({state, done, instr_count}), 128'(0));
    mem_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_instr_sequencer.md
Name: alu_instr_sequencer

Overview:
- Hardwired control unit that sequences the register-register datapath through fetch (T0–T2) and execute (T3–T5) for three-register ALU instructions.
- Drives the datapath's one-hot register-load vector (enable), one-hot bus-driver vector (bus_select), MD_Read and the ALU opcode.
- Replaces the hand-timed stimulus currently used to run instructions.
- Sits beside the datapath and the memory interface; reads back the IR contents to decode.

Parameters:
- MEM_WAIT_MAX, 15, maximum cycles spent in T1 waiting for mem_ready before aborting.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- clr  in  1  synchronous active-high reset
- start  in  1  level; sampled in IDLE; while high, instructions run back-to-back
- mem_ready  in  1  memory read data valid on MDataIn this cycle
- ir  in  32  datapath IR output; fields op[31:27], ra[26:23], rb[22:19], rc[18:15]
- enable  out  32  one-hot-per-function load strobes
  - [15:0] R0–R15in, 20 PCin, 21 MDRin, 23 IRin, 24 Zin, 25 MARin, 27 Yin, 28 IncPC
- bus_select  out  32  bus driver select
  - [15:0] R0–R15out, 19 Zloout, 20 PCout, 21 MDRout
- md_read  out  1  MDR takes memory data rather than bus
- alu_op  out  4  ALU control: 1 ADD, 2 SUB, 3 AND, 4 OR, 0 idle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in the cycle after T5 completes
- illegal  out  1  one-cycle pulse: unsupported opcode detected
- mem_timeout  out  1  one-cycle pulse: T1 wait exceeded MEM_WAIT_MAX
- state  out  4  current state code, for debug
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- States and codes: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6.
- Strobe timing:
  - Strobes are a Moore decode of state and ir, valid for the whole state cycle.
  - The datapath captures on the rising edge that ends the state.
  - At most one bus_select bit is high in any cycle.
- While clr=1, all outputs are forced 0.
- On the clr edge: state<=IDLE, wait counter<=0, instr_count<=0, done/illegal/mem_timeout<=0.
- Reset mid-instruction aborts it with no done pulse and no count increment.
- IDLE: no strobes. start=1 -> T0; else stay.
- T0: bus_select[20]; enable[25], enable[28], enable[24]. -> T1.
- T1:
  - bus_select[19]; enable[20], enable[21]; md_read=1.
  - mem_ready=1 -> T2.
  - Else wait counter++ and stay.
  - If the counter reaches MEM_WAIT_MAX without mem_ready: pulse mem_timeout, -> IDLE.
  - mem_ready on the same cycle the limit is hit: mem_ready wins.
  - Counter clears on leaving T1.
- T2: bus_select[21]; enable[23]. -> T3.
- T3:
  - Decode ir.op: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR.
  - Legal opcode: bus_select[ir.rb]; enable[27]. -> T4.
  - Any other opcode: no strobes, pulse illegal, -> IDLE; instr_count unchanged.
- T4: bus_select[ir.rc]; alu_op=mapped code; enable[24]. -> T5.
- T5: bus_select[19]; enable[ir.ra]. -> T0 if start=1 else IDLE.
  - The next cycle pulses done and increments instr_count.
- Register fields:
  - ra=rb=rc allowed, no special case.
  - R0 is an ordinary register at this level.
- Latency: 6 cycles from T0 to the end of T5 with zero-wait memory; each T1 wait cycle adds 1.
- ir changes outside T3–T5 are ignored.

Test Plan:
- Reset: hold clr 2 cycles mid-T4 of a running instruction -> next cycle state=0, enable=0, bus_select=0, md_read=0, instr_count=0, no done.
- Single AND: R2=5, R3=6 preloaded; start pulsed 1 cycle; MDataIn=0x28918000, mem_ready=1 in first T1 cycle.
  - Per cycle: T0 enable=0x13000000, bus_select=0x00100000; T3 bus_select=0x4, enable=0x08000000; T4 alu_op=3, bus_select=0x8; T5 enable=0x2, bus_select=0x80000.
  - Result: R1=4; done pulse 7 cycles after start; instr_count=1.
- Memory wait: mem_ready delayed 3 cycles -> T1 held 4 cycles with md_read=1; done 3 cycles later than the zero-wait run; R1 still 4.
- Timeout: mem_ready never asserted -> mem_timeout pulses after exactly 15 T1 cycles, state=0, no register written.
- Illegal opcode: IR=0xF8000000 -> illegal pulses after T3, no Yin/Zin strobes, state returns to 0, instr_count unchanged.
- Back-to-back: start held high over ADD then OR (R1=R2+R3, then R4=R1|R2) -> T5 goes directly to T0; R1=0xB, R4=0xF; instr_count=2.
